// File: rtl/test_value_uart_pkg.sv
// Shared types and constants for the test-value UART transmitter.
// The message format is selected in the top by TEST_VALUE_UART_ASCII_EN.
package test_value_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef enum logic {
    MSG_IDLE = 1'b0,
    MSG_SEND = 1'b1
  } msg_state_e;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

  localparam int MSG_LEN_ASCII = 6;
  localparam int MSG_LEN_RAW   = 2;

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = ASCII_DIGIT_BASE + {4'd0, nib};
    end else begin
      ch = ASCII_ALPHA_BASE + ({4'd0, nib} - 8'd10);
    end
    return ch;
  endfunction

endpackage

// File: rtl/test_value_uart_if.sv
// Byte channel between message sequencer (master) and byte serializer (slave).
interface test_value_uart_if;

  logic       load;
  logic [7:0] data;
  logic       done;
  logic       tx;

  modport master (output load, output data, input done, input tx);
  modport slave  (input load, input data, output done, output tx);

endinterface

// File: rtl/test_value_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// A load during the final stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
  import test_value_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic reset_i,
  test_value_uart_if.slave bif
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_c;
  logic             done_c;
  logic             bit_end;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_c      = 1'b1;
    done_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bif.load) begin
          state_d = START;
          cnt_d   = BIT_LAST;
          shift_d = bif.data;
        end
      end

      START: begin
        tx_c = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          cnt_d     = BIT_LAST;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        tx_c = shift_q[0];
        if (bit_end) begin
          cnt_d   = BIT_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STOP: begin
        tx_c = 1'b1;
        if (bit_end) begin
          done_c = 1'b1;
          // Sequencer answers the done pulse combinationally when bytes remain.
          if (bif.load) begin
            state_d = START;
            cnt_d   = BIT_LAST;
            shift_d = bif.data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bif.tx   = tx_c;
  assign bif.done = done_c;

endmodule

// File: rtl/test_value_uart_tx.sv
// Sends test_value over a UART whenever it changes (and once after reset).
// Define TEST_VALUE_UART_ASCII_EN for "HHHH\r\n" text, otherwise 2 raw bytes MSB first.
module test_value_uart_tx
  import test_value_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] test_value,
  output logic        tx,
  output logic        busy
);

`ifdef TEST_VALUE_UART_ASCII_EN
  localparam int MSG_LEN = MSG_LEN_ASCII;
`else
  localparam int MSG_LEN = MSG_LEN_RAW;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  function automatic logic [7:0] msg_byte(input logic [15:0] val, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
`ifdef TEST_VALUE_UART_ASCII_EN
    case (idx)
      3'd0:    b = nibble_to_ascii(val[15:12]);
      3'd1:    b = nibble_to_ascii(val[11:8]);
      3'd2:    b = nibble_to_ascii(val[7:4]);
      3'd3:    b = nibble_to_ascii(val[3:0]);
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
`else
    b = (idx == '0) ? val[15:8] : val[7:0];
`endif
    return b;
  endfunction

  test_value_uart_if u_byte_if ();

  msg_state_e       msg_q, msg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      snapshot_q, snapshot_d;
  logic [15:0]      last_sent_q, last_sent_d;
  logic             sent_once_q, sent_once_d;
  logic             trigger;
  logic             load_c;
  logic [15:0]      sel_val;
  logic [IDX_W-1:0] sel_idx;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i   (clk),
    .reset_i (reset),
    .bif     (u_byte_if.slave)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_q       <= MSG_IDLE;
      idx_q       <= '0;
      snapshot_q  <= '0;
      last_sent_q <= '0;
      sent_once_q <= 1'b0;
    end else begin
      msg_q       <= msg_d;
      idx_q       <= idx_d;
      snapshot_q  <= snapshot_d;
      last_sent_q <= last_sent_d;
      sent_once_q <= sent_once_d;
    end
  end

  assign trigger = (msg_q == MSG_IDLE) && (!sent_once_q || (test_value != last_sent_q));

  always_comb begin
    msg_d       = msg_q;
    idx_d       = idx_q;
    snapshot_d  = snapshot_q;
    last_sent_d = last_sent_q;
    sent_once_d = sent_once_q;
    load_c      = 1'b0;
    sel_val     = snapshot_q;
    sel_idx     = idx_q + IDX_W'(1);

    case (msg_q)
      MSG_IDLE: begin
        if (trigger) begin
          // First byte comes straight from test_value; snapshot lands on the same edge.
          load_c      = 1'b1;
          sel_val     = test_value;
          sel_idx     = '0;
          snapshot_d  = test_value;
          last_sent_d = test_value;
          sent_once_d = 1'b1;
          idx_d       = '0;
          msg_d       = MSG_SEND;
        end
      end

      MSG_SEND: begin
        if (u_byte_if.done) begin
          if (idx_q == LAST_IDX) begin
            msg_d = MSG_IDLE;
          end else begin
            load_c = 1'b1;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        msg_d = MSG_IDLE;
      end
    endcase
  end

  assign u_byte_if.load = load_c;
  assign u_byte_if.data = msg_byte(sel_val, sel_idx);

  assign tx   = u_byte_if.tx;
  assign busy = (msg_q == MSG_SEND);

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Self-checking bench for test_value_uart_tx; follows TEST_VALUE_UART_ASCII_EN like the DUT.
// Expected line waveforms are built from message bytes and compared cycle by cycle.
module tb_test_value_uart_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;
`ifdef TEST_VALUE_UART_ASCII_EN
  localparam int NBYTES      = 6;
  localparam int MSG_CYC_REQ = 240;
`else
  localparam int NBYTES      = 2;
  localparam int MSG_CYC_REQ = 80;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] test_value = 16'h0000;
  logic        busy;

  test_value_uart_if u_probe ();

  int   checks = 0;
  int   errors = 0;
  int   exp_bytes[$];
  bit   exp_wave[$];
  logic cap_bits[$];
  int   rx_bytes[$];
  int   cap_wait;
  bit   cap_timeout;
  logic [15:0] last_val;

  test_value_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .test_value (test_value),
    .tx         (u_probe.tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    u_probe.load = 1'b0;
    u_probe.data = 8'h00;
    u_probe.done = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: bytes of the message, then the ideal 8N1 line waveform for them.
  function automatic void build_expected(input logic [15:0] v);
    int d;
    exp_bytes.delete();
    exp_wave.delete();
`ifdef TEST_VALUE_UART_ASCII_EN
    for (int i = 0; i < 4; i++) begin
      d = (int'(v) >> (12 - 4 * i)) % 16;
      exp_bytes.push_back(d < 10 ? 48 + d : 55 + d);
    end
    exp_bytes.push_back(13);
    exp_bytes.push_back(10);
`else
    exp_bytes.push_back(int'(v) / 256);
    exp_bytes.push_back(int'(v) % 256);
`endif
    foreach (exp_bytes[k]) begin
      for (int c = 0; c < CPB; c++) exp_wave.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < CPB; c++) exp_wave.push_back(bit'((exp_bytes[k] >> b) & 1));
      for (int c = 0; c < CPB; c++) exp_wave.push_back(1'b1);
    end
  endfunction

  function automatic int wave_diffs();
    int n = 0;
    for (int i = 0; i < exp_wave.size(); i++)
      if (i >= cap_bits.size() || cap_bits[i] !== logic'(exp_wave[i])) n++;
    return n;
  endfunction

  function automatic void decode_rx();
    int bval;
    int idx;
    rx_bytes.delete();
    for (int k = 0; k < NBYTES; k++) begin
      bval = 0;
      for (int b = 0; b < 8; b++) begin
        idx = k * BYTE_CYC + CPB + b * CPB + CPB / 2;
        if (idx < cap_bits.size() && cap_bits[idx] === 1'b1) bval |= (1 << b);
      end
      rx_bytes.push_back(bval);
    end
  endfunction

  // Waits for busy, records tx every cycle while busy; returns on the first idle sample.
  task automatic capture_msg();
    cap_bits.delete();
    cap_wait    = 0;
    cap_timeout = 1'b0;
    @(negedge clk);
    while (!busy && cap_wait < 2000) begin
      cap_wait++;
      @(negedge clk);
    end
    if (!busy) begin
      cap_timeout = 1'b1;
      return;
    end
    while (busy && cap_bits.size() < 4000) begin
      cap_bits.push_back(u_probe.tx);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    test_value = 16'h0000;
    repeat (5) @(negedge clk);
    checks++;
    if (u_probe.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", u_probe.tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    build_expected(16'h0000);
    capture_msg();
    decode_rx();
    checks++;
    if (cap_timeout !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %b expected 0", cap_timeout); end
    checks++;
    if (cap_wait !== 0) begin errors++; $display("FAIL zero_start_latency: got %0d expected 0", cap_wait); end
    checks++;
    if (cap_bits.size() !== MSG_CYC_REQ) begin errors++; $display("FAIL zero_busy_len: got %0d expected %0d", cap_bits.size(), MSG_CYC_REQ); end
    checks++;
    if (wave_diffs() !== 0) begin errors++; $display("FAIL zero_wave: got %0d bad cycles expected 0", wave_diffs()); end
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL zero_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_bytes[k]); end
    end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL zero_sent_once: got %0d busy cycles expected 0", bad); end
    last_val = 16'h0000;
  endtask

  task automatic test_vector();
    logic [15:0] v;
`ifdef TEST_VALUE_UART_ASCII_EN
    v = 16'h00A5;
`else
    v = 16'hBEEF;
`endif
    test_value = v;
    build_expected(v);
    capture_msg();
    decode_rx();
    checks++;
    if (cap_timeout !== 1'b0) begin errors++; $display("FAIL vec_timeout: got %b expected 0", cap_timeout); end
    checks++;
    if (cap_bits.size() !== MSG_CYC_REQ) begin errors++; $display("FAIL vec_busy_len: got %0d expected %0d", cap_bits.size(), MSG_CYC_REQ); end
    checks++;
    if (wave_diffs() !== 0) begin errors++; $display("FAIL vec_wave: got %0d bad cycles expected 0", wave_diffs()); end
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL vec_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_bytes[k]); end
    end
    last_val = v;
  endtask

  task automatic test_change_mid_message();
    test_value = 16'h1234;
    fork
      begin
        repeat (20) @(negedge clk);
        test_value = 16'h9999;
        repeat (20) @(negedge clk);
        test_value = 16'h5678;
      end
    join_none
    build_expected(16'h1234);
    capture_msg();
    decode_rx();
    checks++;
    if (cap_bits.size() !== MSG_CYC_REQ) begin errors++; $display("FAIL chg1_busy_len: got %0d expected %0d", cap_bits.size(), MSG_CYC_REQ); end
    checks++;
    if (wave_diffs() !== 0) begin errors++; $display("FAIL chg1_wave: got %0d bad cycles expected 0", wave_diffs()); end
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL chg1_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_bytes[k]); end
    end
    build_expected(16'h5678);
    capture_msg();
    decode_rx();
    checks++;
    if (cap_timeout !== 1'b0) begin errors++; $display("FAIL chg2_timeout: got %b expected 0", cap_timeout); end
    checks++;
    if (cap_wait !== 0) begin errors++; $display("FAIL chg2_gap: got %0d extra idle cycles expected 0", cap_wait); end
    checks++;
    if (wave_diffs() !== 0) begin errors++; $display("FAIL chg2_wave: got %0d bad cycles expected 0", wave_diffs()); end
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL chg2_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_bytes[k]); end
    end
    last_val = 16'h5678;
  endtask

  task automatic test_hold_constant();
    int tx_bad;
    int busy_bad;
    tx_bad = 0;
    busy_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (u_probe.tx !== 1'b1) tx_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    checks++;
    if (tx_bad !== 0) begin errors++; $display("FAIL hold_tx: got %0d low cycles expected 0", tx_bad); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL hold_busy: got %0d busy cycles expected 0", busy_bad); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 5; n++) begin
      v = 16'($urandom_range(0, 65535));
      if (v == last_val) v = v ^ 16'h0001;
      test_value = v;
      build_expected(v);
      capture_msg();
      decode_rx();
      checks++;
      if (cap_bits.size() !== MSG_CYC_REQ) begin errors++; $display("FAIL rnd%0d_busy_len: got %0d expected %0d", n, cap_bits.size(), MSG_CYC_REQ); end
      checks++;
      if (wave_diffs() !== 0) begin errors++; $display("FAIL rnd%0d_wave value %04h: got %0d bad cycles expected 0", n, v, wave_diffs()); end
      for (int k = 0; k < NBYTES; k++) begin
        checks++;
        if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL rnd%0d_byte%0d: got %02h expected %02h", n, k, rx_bytes[k], exp_bytes[k]); end
      end
      last_val = v;
    end
  endtask

  // Reset lands during data bit 3 of byte 1 (cycles 56..59 of the message).
  task automatic test_reset_mid_frame();
    logic [15:0] v;
    int w;
    v = 16'($urandom_range(0, 65535));
    if (v == last_val) v = v ^ 16'h8000;
    test_value = v;
    build_expected(v);
    w = 0;
    @(negedge clk);
    while (!busy && w < 2000) begin
      w++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_start: got busy %b expected 1", busy); end
    repeat (57) @(negedge clk);
    checks++;
    if (u_probe.tx !== logic'(exp_wave[57])) begin errors++; $display("FAIL rst_mid_bit3: got %b expected %b", u_probe.tx, exp_wave[57]); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (u_probe.tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b expected 1", u_probe.tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    reset = 1'b0;
    capture_msg();
    decode_rx();
    checks++;
    if (cap_wait !== 0) begin errors++; $display("FAIL rst_mid_restart: got %0d idle cycles expected 0", cap_wait); end
    checks++;
    if (cap_bits.size() !== MSG_CYC_REQ) begin errors++; $display("FAIL rst_mid_busy_len: got %0d expected %0d", cap_bits.size(), MSG_CYC_REQ); end
    checks++;
    if (wave_diffs() !== 0) begin errors++; $display("FAIL rst_mid_wave: got %0d bad cycles expected 0", wave_diffs()); end
    for (int k = 0; k < NBYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_bytes[k]) begin errors++; $display("FAIL rst_mid_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_bytes[k]); end
    end
    last_val = v;
  endtask

  initial begin
    last_val = 16'h0000;
    test_reset();
    test_vector();
    test_change_mid_message();
    test_hold_constant();
    test_random();
    test_reset_mid_frame();
    test_hold_constant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
